// File: rtl/iot_event_scheduler_pkg.sv
// rtl/iot_event_scheduler_pkg.sv - shared constants, event kinds and classifier for the IoT event scheduler
package iot_event_scheduler_pkg;

  localparam int   N_DEV_DEFAULT = 4;
  localparam int   MON_CNT_W     = 8;
  localparam logic EV_JOIN       = 1'b1;
  localparam logic EV_LEAVE      = 1'b0;

  typedef enum logic [1:0] {
    EV_IDLE    = 2'd0,
    EV_FWD_ON  = 2'd1,
    EV_FWD_OFF = 2'd2,
    EV_DROP    = 2'd3
  } ev_kind_e;

  // An event only reaches the monitor when it changes the device's active state.
  function automatic ev_kind_e classify_event(input logic gnt_valid,
                                              input logic req_on,
                                              input logic active);
    if (!gnt_valid) begin
      return EV_IDLE;
    end
    if ((req_on == EV_JOIN) && !active) begin
      return EV_FWD_ON;
    end
    if ((req_on == EV_LEAVE) && active) begin
      return EV_FWD_OFF;
    end
    return EV_DROP;
  endfunction

endpackage

// File: rtl/iot_event_scheduler_rr_arbiter.sv
// rtl/iot_event_scheduler_rr_arbiter.sv - combinational round-robin picker starting at rr_ptr
module rr_arbiter #(
  parameter int N_DEV = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_DEV-1:0] eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0] idx;

  // Walk offsets 0..N_DEV-1 from rr_ptr; the first eligible device wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 0; i < N_DEV; i++) begin
      idx = {1'b0, rr_ptr} + SW'(i);
      if (idx >= SW'(N_DEV)) begin
        idx = idx - SW'(N_DEV);
      end
      if (!gnt_valid && eligible[idx[PTR_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/iot_event_scheduler.sv
// rtl/iot_event_scheduler.sv - serialises per-device join/leave requests into monitor change/on_off pulses
module iot_event_scheduler
  import iot_event_scheduler_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT,
  parameter int PTR_W = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_DEV-1:0] req,
  input  logic [N_DEV-1:0] req_on,
  output logic [N_DEV-1:0] ack,
  output logic             drop,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] active
);

  logic [N_DEV-1:0] ack_q, ack_d;
  logic             drop_q, drop_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [N_DEV-1:0] active_q, active_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_DEV-1:0] eligible;
  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_idx;
  ev_kind_e         ev_kind;

  // A device acked this cycle still shows req; masking it prevents a double grant.
  assign eligible = req & ~ack_q & {N_DEV{en}};

  rr_arbiter #(
    .N_DEV (N_DEV),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign ev_kind = classify_event(gnt_valid, req_on[gnt_idx], active_q[gnt_idx]);

  always_comb begin
    ack_d    = '0;
    drop_d   = 1'b0;
    change_d = 1'b0;
    on_off_d = 1'b0;
    active_d = active_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      ack_d[gnt_idx] = 1'b1;
      rr_ptr_d       = (gnt_idx == PTR_W'(N_DEV - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    case (ev_kind)
      EV_FWD_ON: begin
        change_d          = 1'b1;
        on_off_d          = 1'b1;
        active_d[gnt_idx] = 1'b1;
      end
      EV_FWD_OFF: begin
        change_d          = 1'b1;
        active_d[gnt_idx] = 1'b0;
      end
      EV_DROP: begin
        drop_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= '0;
      drop_q   <= 1'b0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      active_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      ack_q    <= ack_d;
      drop_q   <= drop_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      active_q <= active_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign ack    = ack_q;
  assign drop   = drop_q;
  assign change = change_q;
  assign on_off = on_off_q;
  assign active = active_q;

endmodule

// File: tb/tb_iot_event_scheduler.sv
// tb/tb_iot_event_scheduler.sv - directed and random checks of iot_event_scheduler against a reference model
module tb_iot_event_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] req_on;
  logic [N-1:0] ack;
  logic         drop;
  logic         change;
  logic         on_off;
  logic [N-1:0] active;

  int errors = 0;
  int checks = 0;
  int mon_count = 0;

  logic [N-1:0] m_ack;
  logic [N-1:0] m_active;
  logic         m_drop;
  logic         m_change;
  logic         m_onoff;
  int           m_ptr;
  int           m_mon;
  bit           auto_drop;

  always #5 clk = ~clk;

  iot_event_scheduler #(.N_DEV(N), .PTR_W(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .req_on (req_on),
    .ack    (ack),
    .drop   (drop),
    .change (change),
    .on_off (on_off),
    .active (active)
  );

  // Stand-in for the active-device monitor counter fed by the scheduler.
  always @(posedge clk) begin
    if (rst) mon_count <= 0;
    else if (change === 1'b1) mon_count <= on_off ? mon_count + 1 : mon_count - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [N-1:0] e;
    int g;
    if (rst) begin
      m_ack = '0; m_drop = 0; m_change = 0; m_onoff = 0;
      m_active = '0; m_ptr = 0; m_mon = 0;
    end else begin
      if (m_change) m_mon += m_onoff ? 1 : -1;
      e = req & ~m_ack & {N{en}};
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && e[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      m_ack = '0; m_drop = 0; m_change = 0; m_onoff = 0;
      if (g >= 0) begin
        m_ack[g] = 1'b1;
        m_ptr = (g + 1) % N;
        if (req_on[g] != m_active[g]) begin
          m_change = 1; m_onoff = req_on[g]; m_active[g] = req_on[g];
        end else begin
          m_drop = 1;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk({tag, ".ack"}, ack, m_ack);
    chk({tag, ".drop"}, drop, m_drop);
    chk({tag, ".change"}, change, m_change);
    if (m_change) chk({tag, ".on_off"}, on_off, m_onoff);
    chk({tag, ".active"}, active, m_active);
    chk({tag, ".count"}, mon_count, m_mon);
    if (auto_drop) req = req & ~m_ack;
  endtask

  task automatic wait_ack(input int dev, input string tag);
    int n = 0;
    do begin
      step(tag);
      n++;
    end while (!m_ack[dev] && n < 10);
    chk({tag, ".acked"}, ack[dev], 1'b1);
  endtask

  initial begin
    logic [N-1:0] oh;
    auto_drop = 1;
    m_ack = '0; m_active = '0; m_drop = 0; m_change = 0; m_onoff = 0; m_ptr = 0; m_mon = 0;
    rst = 1; en = 1; req = 4'b1111; req_on = 4'b1111;

    repeat (3) step("reset");
    chk("reset.ack0", ack, 4'b0000);
    chk("reset.change0", change, 1'b0);
    chk("reset.active0", active, 4'b0000);
    chk("reset.count0", mon_count, 0);
    rst = 0; req = '0;

    req[2] = 1; req_on[2] = 1;
    step("join2");
    chk("join2.ack", ack, 4'b0100);
    chk("join2.on_off", on_off, 1'b1);
    chk("join2.active", active, 4'b0100);
    step("join2_idle");
    chk("join2.noregrant", ack, 4'b0000);
    chk("join2.count", mon_count, 1);

    rst = 1; step("rst_mid"); rst = 0; req = '0;

    req = 4'b1111; req_on = 4'b1111;
    for (int k = 0; k < N; k++) begin
      step("fair");
      oh = 4'(1 << k);
      chk("fair.order", ack, oh);
    end
    step("fair_idle");
    chk("fair.active", active, 4'b1111);
    chk("fair.count", mon_count, 4);

    req[1] = 1; req_on[1] = 1;
    wait_ack(1, "redun_join");
    chk("redun_join.drop", drop, 1'b1);
    chk("redun_join.change", change, 1'b0);
    req[3] = 1; req_on[3] = 0;
    wait_ack(3, "leave3");
    chk("leave3.dec", {change, on_off}, 2'b10);
    req[3] = 1; req_on[3] = 0;
    wait_ack(3, "redun_leave");
    chk("redun_leave.drop", drop, 1'b1);
    step("redun_idle");
    chk("redun_leave.count", mon_count, 3);
    req[3] = 1; req_on[3] = 1;
    wait_ack(3, "rejoin3");
    step("rejoin_idle");
    chk("rejoin3.count", mon_count, 4);

    en = 0; req = 4'b1111; req_on = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step("en_off");
      chk("en_off.noack", ack, 4'b0000);
    end
    chk("en_off.active", active, 4'b1111);
    en = 1;
    repeat (6) step("en_on");
    chk("en_on.active", active, 4'b0000);
    chk("en_on.count", mon_count, 0);

    req = 4'b1111; req_on = 4'b1111;
    step("burst");
    rst = 1;
    step("burst_rst");
    chk("burst_rst.ack", ack, 4'b0000);
    chk("burst_rst.outs", {drop, change, on_off}, 3'b000);
    chk("burst_rst.active", active, 4'b0000);
    rst = 0; req = '0;
    step("post_rst");
    req = 4'b1000; req_on = 4'b1000;
    step("post_rst_g3");
    chk("post_rst.grant3", ack, 4'b1000);
    step("post_rst_idle");
    chk("post_rst.count", mon_count, 1);

    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      if (rst) req = '0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_on[i] = 1'($urandom_range(0, 1));
        end else if (req[i] && $urandom_range(0, 4) == 0) begin
          req_on[i] = 1'($urandom_range(0, 1));
        end
      end
      step("rand");
    end
    rst = 0; req = '0;
    step("final");
    chk("final.count_vs_active", mon_count, $countones(m_active));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
